// File: rtl/tap_ir_dr.sv
// JTAG instruction register and IDCODE/BYPASS/USER data registers behind the TAP controller.
// Define TAP_USER_DR_EN to build the USER data register and its parallel update handshake.
module tap_ir_dr #(
    parameter int              IR_W         = 5,
    parameter logic [31:0]     IDCODE_VAL   = 32'h1000_0001,
    parameter int              USER_W       = 32,
    parameter logic [IR_W-1:0] INSTR_IDCODE = IR_W'('h01),
    parameter logic [IR_W-1:0] INSTR_USER   = IR_W'('h11)
) (
    input  logic              tck_i,
    input  logic              trst_i,
    input  logic              tlr_i,
    input  logic              tdi_i,
    input  logic              capture_ir_i,
    input  logic              shift_ir_i,
    input  logic              update_ir_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              select_ir_i,
    input  logic [USER_W-1:0] user_cap_i,
    output logic              tdo_o,
    output logic [IR_W-1:0]   ir_o,
    output logic [USER_W-1:0] user_data_o,
    output logic              user_valid_o
);

    typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_USER} dr_sel_t;

    logic [IR_W-1:0] ir_sr;
    logic [IR_W-1:0] ir_q;
    logic [31:0]     id_sr;
    logic            byp_q;
    dr_sel_t         dr_dec;
    dr_sel_t         dr_sel;
    logic            user_bit;
    logic            tdo_d;

    always_comb begin
        dr_dec = SEL_BYP;
        if (ir_q == INSTR_IDCODE) begin
            dr_dec = SEL_ID;
        end else if (ir_q == INSTR_USER) begin
`ifdef TAP_USER_DR_EN
            dr_dec = SEL_USER;
`else
            dr_dec = SEL_BYP;
`endif
        end
    end

    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            ir_sr <= '0;
        end else if (capture_ir_i) begin
            ir_sr <= IR_W'(2'b01);
        end else if (shift_ir_i) begin
            ir_sr <= {tdi_i, ir_sr[IR_W-1:1]};
        end
    end

    always_ff @(negedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            ir_q <= INSTR_IDCODE;
        end else if (tlr_i) begin
            ir_q <= INSTR_IDCODE;
        end else if (update_ir_i) begin
            ir_q <= ir_sr;
        end
    end

    // DR selection is frozen at Capture-DR so a later IR update cannot retarget a scan in flight
    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            dr_sel <= SEL_ID;
        end else if (capture_dr_i) begin
            dr_sel <= dr_dec;
        end
    end

    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            id_sr <= '0;
        end else if (capture_dr_i) begin
            if (dr_dec == SEL_ID) id_sr <= IDCODE_VAL | 32'd1;
        end else if (shift_dr_i && dr_sel == SEL_ID) begin
            id_sr <= {tdi_i, id_sr[31:1]};
        end
    end

    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            byp_q <= 1'b0;
        end else if (capture_dr_i) begin
            if (dr_dec == SEL_BYP) byp_q <= 1'b0;
        end else if (shift_dr_i && dr_sel == SEL_BYP) begin
            byp_q <= tdi_i;
        end
    end

`ifdef TAP_USER_DR_EN
    logic [USER_W-1:0] user_sr;

    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            user_sr <= '0;
        end else if (capture_dr_i) begin
            if (dr_dec == SEL_USER) user_sr <= user_cap_i;
        end else if (shift_dr_i && dr_sel == SEL_USER) begin
            user_sr <= {tdi_i, user_sr[USER_W-1:1]};
        end
    end

    always_ff @(negedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            user_data_o  <= '0;
            user_valid_o <= 1'b0;
        end else begin
            user_valid_o <= 1'b0;
            if (update_dr_i && dr_sel == SEL_USER) begin
                user_data_o  <= user_sr;
                user_valid_o <= 1'b1;
            end
        end
    end

    assign user_bit = user_sr[0];
`else
    logic unused_user;

    assign unused_user  = ^{user_cap_i, update_dr_i};
    assign user_bit     = 1'b0;
    assign user_data_o  = '0;
    assign user_valid_o = 1'b0;
`endif

    always_comb begin
        tdo_d = byp_q;
        if (select_ir_i) begin
            tdo_d = ir_sr[0];
        end else if (dr_sel == SEL_ID) begin
            tdo_d = id_sr[0];
        end else if (dr_sel == SEL_USER) begin
            tdo_d = user_bit;
        end
    end

    always_ff @(negedge tck_i or negedge trst_i) begin
        if (!trst_i) begin
            tdo_o <= 1'b0;
        end else begin
            tdo_o <= tdo_d;
        end
    end

    assign ir_o = ir_q;

endmodule
